ramrom_aux_arbiter: RTL and testbench

Shares the Atom RAM/ROM box memory chips between the 6502 and a secondary (auxiliary) requester such as an SD/serial ROM loader. The CPU always owns the memory while PHI2 is high. The arbiter measures each PHI2-low phase and uses that measurement to fit at most one fixed-length auxiliary access into a low phase. It sits between the existing chip-select/strobe decode and the memory pins, and drives the mux select that hands address, chip-select and strobes to the auxiliary side.

---
 rtl/ramrom_aux_arbiter_if.sv | 39 +++
 rtl/ramrom_aux_arbiter.sv | 134 +++++++++++++
 tb/tb_ramrom_aux_arbiter.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/ramrom_aux_arbiter_if.sv
// ramrom_aux_arbiter_if: bus between the aux requester / memory side and the RAM/ROM aux arbiter.
//   aux_req, aux_rw, aux_addr[17:0], aux_wdata[7:0]  requester -> arbiter (aux_addr[17]: 1 = ROM)
//   aux_ack, aux_rdata[7:0]                         arbiter -> requester
//   mem_rdata[7:0]                                  memory data bus as sampled from the chips
//   aux_own, mem_addr[16:0], n_aux_ram_cs, n_aux_rom_cs, n_aux_rds, n_aux_wds, mem_data_oe
//                                                   arbiter -> memory pin mux
//   low_len[CNTW-1:0], overrun                      status
interface ramrom_aux_arbiter_if #(
    parameter int CNTW = 6
);
    logic            aux_req;
    logic            aux_rw;
    logic [17:0]     aux_addr;
    logic [7:0]      aux_wdata;
    logic            aux_ack;
    logic [7:0]      aux_rdata;
    logic [7:0]      mem_rdata;
    logic            aux_own;
    logic [16:0]     mem_addr;
    logic            n_aux_ram_cs;
    logic            n_aux_rom_cs;
    logic            n_aux_rds;
    logic            n_aux_wds;
    logic            mem_data_oe;
    logic [CNTW-1:0] low_len;
    logic            overrun;

    modport master (
        output aux_req, aux_rw, aux_addr, aux_wdata, mem_rdata,
        input  aux_ack, aux_rdata, aux_own, mem_addr, n_aux_ram_cs, n_aux_rom_cs,
               n_aux_rds, n_aux_wds, mem_data_oe, low_len, overrun
    );

    modport slave (
        input  aux_req, aux_rw, aux_addr, aux_wdata, mem_rdata,
        output aux_ack, aux_rdata, aux_own, mem_addr, n_aux_ram_cs, n_aux_rom_cs,
               n_aux_rds, n_aux_wds, mem_data_oe, low_len, overrun
    );
endinterface

// File: rtl/ramrom_aux_arbiter.sv
// ramrom_aux_arbiter: fits at most one fixed-length aux memory access into each measured PHI2-low phase.
//   clk    master clock (>= 4x PHI2)
//   rst_n  asynchronous active-low reset
//   phi2   6502 PHI2, asynchronous, synchronised internally
//   bus    ramrom_aux_arbiter_if.slave: aux request/ack, memory mux controls, status
module ramrom_aux_arbiter #(
    parameter int ACC_CYCLES = 4,
    parameter int GUARD      = 1,
    parameter int CNTW       = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 phi2,
    ramrom_aux_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {HIGH, LOW, ACC, ACK} state_t;

    localparam int              KW      = $clog2(ACC_CYCLES);
    localparam logic [KW-1:0]   K_LAST  = KW'(ACC_CYCLES - 1);
    localparam logic [KW-1:0]   K_CAP   = KW'(ACC_CYCLES - 2);
    // 2 synchroniser clocks plus the decision clock are lost before the access starts
    localparam logic [CNTW-1:0] MIN_LEN = CNTW'(ACC_CYCLES + GUARD + 3);

    state_t          state_q, state_d;
    logic [KW-1:0]   k_q, k_d;
    logic [1:0]      sync_q, sync_d;
    logic            prev_q, prev_d;
    logic [CNTW-1:0] low_cnt_q, low_cnt_d;
    logic [CNTW-1:0] low_len_q, low_len_d;
    logic            valid_q, valid_d;
    logic            overrun_q, overrun_d;
    logic [7:0]      rdata_q, rdata_d;
    logic            own_q, own_d;
    logic            ram_cs_n_q, ram_cs_n_d;
    logic            rom_cs_n_q, rom_cs_n_d;
    logic            rds_n_q, rds_n_d;
    logic            wds_n_q, wds_n_d;
    logic            oe_q, oe_d;
    logic            ack_q, ack_d;
    logic            phi2s, fall, rise, strobe;

    assign phi2s = sync_q[1];
    assign fall  = prev_q & ~phi2s;
    assign rise  = ~prev_q & phi2s;

    always_comb begin
        sync_d    = {sync_q[0], phi2};
        prev_d    = phi2s;
        state_d   = state_q;
        k_d       = k_q;
        overrun_d = overrun_q;
        rdata_d   = rdata_q;
        low_cnt_d = fall ? CNTW'(1) : (!phi2s && low_cnt_q != '1) ? low_cnt_q + CNTW'(1) : low_cnt_q;
        low_len_d = rise ? low_cnt_q : low_len_q;
        valid_d   = valid_q | rise;
        case (state_q)
            HIGH: if (fall) begin
                state_d = (bus.aux_req && valid_q && low_len_q >= MIN_LEN) ? ACC : LOW;
                k_d     = '0;
            end
            LOW:  if (rise) state_d = HIGH;
            ACC:  if (rise) begin
                state_d   = HIGH;
                overrun_d = 1'b1;
            end else begin
                if (k_q == K_CAP && bus.aux_rw) rdata_d = bus.mem_rdata;
                state_d = (k_q == K_LAST) ? ACK : ACC;
                k_d     = k_q + KW'(1);
            end
            ACK:  state_d = rise ? HIGH : LOW;
            default: state_d = HIGH;
        endcase
        // Control outputs are registered from the next state so they line up with it
        own_d      = state_d == ACC;
        strobe     = own_d && k_d != '0 && k_d != K_LAST;
        ram_cs_n_d = !(own_d && !bus.aux_addr[17]);
        rom_cs_n_d = !(own_d && bus.aux_addr[17]);
        rds_n_d    = !(strobe && bus.aux_rw);
        wds_n_d    = !(strobe && !bus.aux_rw);
        oe_d       = own_d && k_d != '0 && !bus.aux_rw;
        ack_d      = state_d == ACK;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= HIGH;
            k_q        <= '0;
            sync_q     <= 2'b11;
            prev_q     <= 1'b1;
            low_cnt_q  <= '0;
            low_len_q  <= '0;
            valid_q    <= 1'b0;
            overrun_q  <= 1'b0;
            rdata_q    <= '0;
            own_q      <= 1'b0;
            ram_cs_n_q <= 1'b1;
            rom_cs_n_q <= 1'b1;
            rds_n_q    <= 1'b1;
            wds_n_q    <= 1'b1;
            oe_q       <= 1'b0;
            ack_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            sync_q     <= sync_d;
            prev_q     <= prev_d;
            low_cnt_q  <= low_cnt_d;
            low_len_q  <= low_len_d;
            valid_q    <= valid_d;
            overrun_q  <= overrun_d;
            rdata_q    <= rdata_d;
            own_q      <= own_d;
            ram_cs_n_q <= ram_cs_n_d;
            rom_cs_n_q <= rom_cs_n_d;
            rds_n_q    <= rds_n_d;
            wds_n_q    <= wds_n_d;
            oe_q       <= oe_d;
            ack_q      <= ack_d;
        end
    end

    // A PHI2 rise hands the bus straight back to the CPU in the same clock (abort path)
    assign bus.aux_own      = own_q & ~rise;
    assign bus.n_aux_ram_cs = ram_cs_n_q | rise;
    assign bus.n_aux_rom_cs = rom_cs_n_q | rise;
    assign bus.n_aux_rds    = rds_n_q | rise;
    assign bus.n_aux_wds    = wds_n_q | rise;
    assign bus.mem_data_oe  = oe_q & ~rise;
    assign bus.mem_addr     = bus.aux_own ? bus.aux_addr[16:0] : '0;
    assign bus.aux_ack      = ack_q;
    assign bus.aux_rdata    = rdata_q;
    assign bus.low_len      = low_len_q;
    assign bus.overrun      = overrun_q;
endmodule

// File: tb/tb_ramrom_aux_arbiter.sv
// tb_ramrom_aux_arbiter: directed bench for ramrom_aux_arbiter (ACC_CYCLES=4, GUARD=1, CNTW=6).
module tb_ramrom_aux_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    logic phi2;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    int   cnt [7];
    int   base [7];
    int   ack_cyc = 0;
    int   fall_cyc = 0;
    logic [16:0] last_addr = '0;

    ramrom_aux_arbiter_if bus ();

    ramrom_aux_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .phi2  (phi2),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial for (int i = 0; i < 7; i++) cnt[i] = 0;

    // Per-cycle activity totals: 0 own, 1 rom cs, 2 ram cs, 3 rds, 4 wds, 5 oe, 6 ack
    always @(negedge clk) if (rst_n) begin
        if (bus.aux_own) begin
            cnt[0]    <= cnt[0] + 1;
            last_addr <= bus.mem_addr;
        end
        if (!bus.n_aux_rom_cs) cnt[1] <= cnt[1] + 1;
        if (!bus.n_aux_ram_cs) cnt[2] <= cnt[2] + 1;
        if (!bus.n_aux_rds)    cnt[3] <= cnt[3] + 1;
        if (!bus.n_aux_wds)    cnt[4] <= cnt[4] + 1;
        if (bus.mem_data_oe)   cnt[5] <= cnt[5] + 1;
        if (bus.aux_ack) begin
            cnt[6]  <= cnt[6] + 1;
            ack_cyc <= cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic snap();
        for (int i = 0; i < 7; i++) base[i] = cnt[i];
    endtask

    task automatic expect_phase(input string t, input int own, rom, ram, rds, wds, oe, ack);
        check({t, ".own"}, cnt[0] - base[0], own);
        check({t, ".romcs"}, cnt[1] - base[1], rom);
        check({t, ".ramcs"}, cnt[2] - base[2], ram);
        check({t, ".rds"}, cnt[3] - base[3], rds);
        check({t, ".wds"}, cnt[4] - base[4], wds);
        check({t, ".oe"}, cnt[5] - base[5], oe);
        check({t, ".ack"}, cnt[6] - base[6], ack);
    endtask

    // Called at posedge+2: PHI2 low for lo clocks, then high for hi clocks
    task automatic period(input int lo, input int hi);
        phi2 = 1'b0;
        fall_cyc = cyc;
        repeat (lo) begin @(posedge clk); #2; end
        phi2 = 1'b1;
        repeat (hi) begin @(posedge clk); #2; end
    endtask

    task automatic req(input logic rw, input logic [17:0] addr, input logic [7:0] wd, input logic [7:0] rd);
        bus.aux_req   = 1'b1;
        bus.aux_rw    = rw;
        bus.aux_addr  = addr;
        bus.aux_wdata = wd;
        bus.mem_rdata = rd;
    endtask

    initial begin
        rst_n = 1'b0;
        phi2 = 1'b1;
        bus.aux_req = 1'b0;
        bus.aux_rw = 1'b1;
        bus.aux_addr = '0;
        bus.aux_wdata = '0;
        bus.mem_rdata = '0;
        repeat (3) begin
            repeat (3) @(posedge clk);
            #2 phi2 = 1'b0;
            repeat (3) @(posedge clk);
            #2 phi2 = 1'b1;
        end
        @(negedge clk);
        check("rst.ctrl", {24'd0, bus.aux_own, bus.n_aux_ram_cs, bus.n_aux_rom_cs, bus.n_aux_rds,
                           bus.n_aux_wds, bus.mem_data_oe, bus.aux_ack, bus.overrun}, 32'h78);
        check("rst.rdata", bus.aux_rdata, 0);
        check("rst.lowlen", bus.low_len, 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        req(1'b1, 18'h20123, 8'h00, 8'hA5);
        // no measurement yet: first low phase never granted
        snap(); period(12, 12);
        expect_phase("first", 0, 0, 0, 0, 0, 0, 0);
        check("first.lowlen", bus.low_len, 12);
        // ROM read; ack = 2 synchroniser clocks + ACC_CYCLES+1 after the PHI2 drive edge
        snap(); period(12, 12);
        expect_phase("rd", 4, 4, 0, 2, 0, 0, 1);
        check("rd.acklat", ack_cyc - fall_cyc, 7);
        check("rd.rdata", bus.aux_rdata, 8'hA5);
        check("rd.addr", last_addr, 17'h00123);
        // RAM write
        req(1'b0, 18'h00A00, 8'h3C, 8'h00);
        snap(); period(12, 12);
        expect_phase("wr", 4, 0, 4, 0, 2, 3, 1);
        check("wr.addr", last_addr, 17'h00A00);
        check("wr.rdata_kept", bus.aux_rdata, 8'hA5);
        // short phases
        bus.aux_req = 1'b0;
        snap(); period(7, 12);
        check("idle7.lowlen", bus.low_len, 7);
        req(1'b1, 18'h00055, 8'h00, 8'h5A);
        snap(); period(7, 12);
        expect_phase("short7", 0, 0, 0, 0, 0, 0, 0);
        snap(); period(8, 12);
        expect_phase("meas8", 0, 0, 0, 0, 0, 0, 0);
        check("meas8.lowlen", bus.low_len, 8);
        snap(); period(8, 12);
        expect_phase("len8", 4, 0, 4, 2, 0, 0, 1);
        check("len8.rdata", bus.aux_rdata, 8'h5A);
        // overrun: 12 measured, then a 4-clock low phase aborts the write
        bus.aux_req = 1'b0;
        snap(); period(12, 12);
        check("pre.overrun", bus.overrun, 0);
        req(1'b0, 18'h00777, 8'h81, 8'h00);
        snap(); period(4, 12);
        expect_phase("abort", 3, 0, 3, 0, 2, 2, 0);
        check("abort.overrun", bus.overrun, 1);
        check("abort.lowlen", bus.low_len, 4);
        snap(); period(12, 12);
        expect_phase("remeas", 0, 0, 0, 0, 0, 0, 0);
        snap(); period(12, 12);
        expect_phase("retry", 4, 0, 4, 0, 2, 3, 1);
        check("retry.addr", last_addr, 17'h00777);
        check("retry.overrun", bus.overrun, 1);
        // back-to-back with request held
        req(1'b1, 18'h20001, 8'h00, 8'hC3);
        for (int i = 0; i < 3; i++) begin
            snap(); period(12, 12);
            expect_phase($sformatf("b2b%0d", i), 4, 4, 0, 2, 0, 0, 1);
        end
        check("b2b.rdata", bus.aux_rdata, 8'hC3);
        // reset in the middle of an access
        phi2 = 1'b0;
        repeat (4) begin @(posedge clk); #2; end
        check("mid.own_before", bus.aux_own, 1);
        rst_n = 1'b0;
        #1;
        check("mid.ctrl", {27'd0, bus.aux_own, bus.n_aux_ram_cs, bus.n_aux_rom_cs, bus.n_aux_rds,
                           bus.n_aux_wds}, 32'h0F);
        check("mid.overrun", bus.overrun, 0);
        phi2 = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
